// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared state, geometry and request types for the SDRAM host adapter
package sdram_pkg;

    localparam int SDRAM_ROW_WIDTH   = 13;
    localparam int SDRAM_COL_WIDTH   = 9;
    localparam int SDRAM_BANK_WIDTH  = 2;
    localparam int SDRAM_HADDR_WIDTH = SDRAM_BANK_WIDTH + SDRAM_ROW_WIDTH + SDRAM_COL_WIDTH;

    typedef enum logic [2:0] {
        ST_WAIT_INIT,
        ST_IDLE,
        ST_ISSUE,
        ST_ACTIVE,
        ST_CAPTURE
    } state_t;

    typedef struct packed {
        logic                         we;
        logic [SDRAM_HADDR_WIDTH-1:0] addr;
        logic [15:0]                  wdata;
    } req_t;

    function automatic int haddr_width(input int bank, input int row, input int col);
        return bank + row + col;
    endfunction

endpackage

// File: rtl/sdram_req_fifo.sv
// rtl/sdram_req_fifo.sv - synchronous request FIFO, async active-low reset
module sdram_req_fifo #(
    parameter int WIDTH = 41,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sdram_host_adapter.sv
// rtl/sdram_host_adapter.sv - valid/ready request adapter in front of the SDRAM controller
// Optional request FIFO: SDRAM_HOST_REQ_FIFO_EN (default build uses a single holding register).
module sdram_host_adapter
    import sdram_pkg::*;
#(
    parameter int ROW_WIDTH        = SDRAM_ROW_WIDTH,
    parameter int COL_WIDTH        = SDRAM_COL_WIDTH,
    parameter int BANK_WIDTH       = SDRAM_BANK_WIDTH,
    parameter int HADDR_WIDTH      = haddr_width(BANK_WIDTH, ROW_WIDTH, COL_WIDTH),
    parameter int INIT_WAIT        = 32,
    parameter int RD_CAPTURE_DELAY = 1,
    parameter int ACCEPT_TIMEOUT   = 31,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [HADDR_WIDTH-1:0] req_addr,
    input  logic [15:0]            req_wdata,
    output logic                   rsp_valid,
    output logic [15:0]            rsp_rdata,
    output logic                   err,
    output logic [HADDR_WIDTH-1:0] haddr,
    output logic [15:0]            data_input,
    output logic                   rd_enable,
    output logic                   wr_enable,
    input  logic                   busy,
    input  logic [15:0]            data_output
);

    localparam int REQ_W  = 1 + HADDR_WIDTH + 16;
    localparam int OCC_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int INIT_W = $clog2(INIT_WAIT) + 1;

    state_t                 state;
    state_t                 state_next;
    logic [INIT_W-1:0]      init_cnt;
    logic [3:0]             cap_cnt;
    logic [7:0]             to_cnt;
    logic                   cur_we;
    logic                   timeout;

    logic                   push;
    logic                   pop;
    logic                   pending;
    logic [REQ_W-1:0]       head;
    logic [OCC_W-1:0]       occ;
    logic [OCC_W-1:0]       occ_next;
    logic                   room_state;

    logic                   ready_d;
    logic                   rsp_valid_d;
    logic [15:0]            rsp_rdata_d;
    logic                   err_d;
    logic [HADDR_WIDTH-1:0] haddr_d;
    logic [15:0]            data_input_d;
    logic                   rd_en_d;
    logic                   wr_en_d;

`ifdef SDRAM_HOST_REQ_FIFO_EN
    localparam int CAP = FIFO_DEPTH;
    logic fifo_full;
    logic fifo_empty;

    assign push       = req_valid & req_ready & ~fifo_full;
    assign pending    = ~fifo_empty;
    assign room_state = (state_next != ST_WAIT_INIT);

    sdram_req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({req_we, req_addr, req_wdata}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (occ)
    );
`else
    localparam int CAP = 1;
    logic             hold_valid;
    logic [REQ_W-1:0] hold_q;

    // Ready only in IDLE, so a push can never coincide with a pop here.
    assign push       = req_valid & req_ready;
    assign pending    = hold_valid;
    assign head       = hold_q;
    assign occ        = OCC_W'(hold_valid);
    assign room_state = (state_next == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
            hold_q     <= '0;
        end else if (push) begin
            hold_valid <= 1'b1;
            hold_q     <= {req_we, req_addr, req_wdata};
        end else if (pop) begin
            hold_valid <= 1'b0;
        end
    end
`endif

    assign pop      = (state == ST_IDLE) && pending;
    assign occ_next = occ + OCC_W'(push) - OCC_W'(pop);
    assign timeout  = (state == ST_ISSUE) && !busy && (to_cnt == 8'(ACCEPT_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_WAIT_INIT;
            init_cnt   <= INIT_W'(INIT_WAIT - 1);
            cap_cnt    <= '0;
            to_cnt     <= '0;
            cur_we     <= 1'b0;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            err        <= 1'b0;
            haddr      <= '0;
            data_input <= '0;
            rd_enable  <= 1'b0;
            wr_enable  <= 1'b0;
        end else begin
            state      <= state_next;
            req_ready  <= ready_d;
            rsp_valid  <= rsp_valid_d;
            rsp_rdata  <= rsp_rdata_d;
            err        <= err_d;
            haddr      <= haddr_d;
            data_input <= data_input_d;
            rd_enable  <= rd_en_d;
            wr_enable  <= wr_en_d;
            if (state == ST_WAIT_INIT && init_cnt != '0) init_cnt <= init_cnt - 1'b1;
            if (pop) begin
                cur_we <= head[REQ_W-1];
                to_cnt <= '0;
            end else if (state == ST_ISSUE) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (state == ST_ACTIVE) cap_cnt <= 4'(RD_CAPTURE_DELAY);
            else if (state == ST_CAPTURE && cap_cnt != '0) cap_cnt <= cap_cnt - 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_WAIT_INIT: if (init_cnt == '0) state_next = ST_IDLE;
            ST_IDLE:      if (pending) state_next = ST_ISSUE;
            ST_ISSUE: begin
                if (busy)         state_next = ST_ACTIVE;
                else if (timeout) state_next = ST_IDLE;
            end
            ST_ACTIVE:    if (!busy) state_next = cur_we ? ST_IDLE : ST_CAPTURE;
            ST_CAPTURE:   if (cap_cnt == '0) state_next = ST_IDLE;
            default:      state_next = ST_WAIT_INIT;
        endcase
    end

    // Next values for the registered outputs.
    always_comb begin
        haddr_d      = haddr;
        data_input_d = data_input;
        rd_en_d      = rd_enable;
        wr_en_d      = wr_enable;
        rsp_valid_d  = 1'b0;
        rsp_rdata_d  = rsp_rdata;
        err_d        = err | timeout;
        ready_d      = room_state && (occ_next < OCC_W'(CAP));
        case (state)
            ST_IDLE: begin
                if (pending) begin
                    haddr_d      = head[HADDR_WIDTH+15:16];
                    data_input_d = head[15:0];
                    rd_en_d      = ~head[REQ_W-1];
                    wr_en_d      = head[REQ_W-1];
                end
            end
            ST_ISSUE: begin
                if (busy || timeout) begin
                    rd_en_d = 1'b0;
                    wr_en_d = 1'b0;
                end
                // A read that never got accepted still owes the host a response.
                if (timeout && rd_enable) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                end
            end
            ST_CAPTURE: begin
                rd_en_d = 1'b0;
                wr_en_d = 1'b0;
                if (cap_cnt == '0) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = data_output;
                end
            end
            default: begin
                rd_en_d = 1'b0;
                wr_en_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sdram_host_adapter.sv
// tb/tb_sdram_host_adapter.sv - directed self-checking bench with a behavioural controller model
module tb_sdram_host_adapter;

    localparam int HW   = 24;
    localparam int INIT = 32;
    localparam int RCD  = 1;
    localparam int ATO  = 31;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [HW-1:0] req_addr;
    logic [15:0]   req_wdata;
    logic          rsp_valid;
    logic [15:0]   rsp_rdata;
    logic          err;
    logic [HW-1:0] haddr;
    logic [15:0]   data_input;
    logic          rd_enable;
    logic          wr_enable;
    logic          busy;
    logic [15:0]   data_output;

    always #5 clk = ~clk;

    sdram_host_adapter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .err         (err),
        .haddr       (haddr),
        .data_input  (data_input),
        .rd_enable   (rd_enable),
        .wr_enable   (wr_enable),
        .busy        (busy),
        .data_output (data_output)
    );

    int checks = 0;
    int failures = 0;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Controller model: busy rises m_lat cycles after it sees an enable, stays high m_len cycles.
    int          m_lat = 2;
    int          m_len = 3;
    bit          m_stuck = 1'b0;
    int          m_st;
    int          m_cnt;
    logic        m_we;
    logic [HW-1:0] m_addr;
    logic [15:0] m_din;
    logic [15:0] mem [256];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= 1'b0;
            data_output <= 16'h0;
            m_st        <= 0;
            m_cnt       <= 0;
        end else if (m_st == 0) begin
            if ((rd_enable || wr_enable) && !m_stuck) begin
                m_we   <= wr_enable;
                m_addr <= haddr;
                m_din  <= data_input;
                if (m_lat <= 1) begin
                    busy <= 1'b1; m_st <= 2; m_cnt <= m_len;
                end else begin
                    m_st <= 1; m_cnt <= m_lat - 1;
                end
            end
        end else if (m_st == 1) begin
            if (m_cnt == 1) begin
                busy <= 1'b1; m_st <= 2; m_cnt <= m_len;
            end else m_cnt <= m_cnt - 1;
        end else begin
            if (m_cnt == 1) begin
                busy <= 1'b0;
                m_st <= 0;
                if (m_we) mem[m_addr[7:0]] <= m_din;
                else data_output <= mem[m_addr[7:0]];
            end else m_cnt <= m_cnt - 1;
        end
    end

    int            cyc = 0;
    int            en_run = 0;
    int            en_width = 0;
    int            rsp_count = 0;
    int            fall_cyc = 0;
    logic          prev_busy = 1'b0;
    logic          prev_en = 1'b0;
    logic [HW-1:0] issued [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rd_enable || wr_enable) begin
            if (!prev_en) issued.push_back(haddr);
            en_run++;
        end else if (prev_en) begin
            en_width = en_run;
            en_run = 0;
        end
        prev_en = rd_enable || wr_enable;
        if (prev_busy && !busy) fall_cyc = cyc;
        prev_busy = busy;
        if (rsp_valid) rsp_count++;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_init(input string tag);
        int n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        expect_eq(tag, n, INIT);
    endtask

    task automatic send(input logic we, input logic [HW-1:0] addr, input logic [15:0] data);
        int n = 0;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) expect_eq("send_timeout", 0, 1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input logic [15:0] exp, input bit check_lat);
        int n = 0;
        while (!rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        expect_eq({tag, "_seen"}, rsp_valid, 1);
        expect_eq(tag, rsp_rdata, exp);
        // busy fall is sampled by the adapter one edge after it becomes visible
        if (check_lat) expect_eq({tag, "_lat"}, cyc - (fall_cyc + 1), RCD + 1);
        @(negedge clk);
        expect_eq({tag, "_pulse"}, rsp_valid, 0);
    endtask

    initial begin
        int base;
        int rsp_snap;
        int n;
        req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0;
        rst_n = 1'b0;
        wait_cycles(3);
        expect_eq("rst_ready", req_ready, 0);
        expect_eq("rst_rsp_valid", rsp_valid, 0);
        expect_eq("rst_err", err, 0);
        expect_eq("rst_rd_en", rd_enable, 0);
        expect_eq("rst_wr_en", wr_enable, 0);
        expect_eq("rst_haddr", haddr, 0);
        expect_eq("rst_data_input", data_input, 0);
        expect_eq("rst_rsp_rdata", rsp_rdata, 0);
        rst_n = 1'b1;
        wait_init("init_wait");

        base = issued.size();
        send(1'b1, 24'h012345, 16'hBEEF);
`ifndef SDRAM_HOST_REQ_FIFO_EN
        expect_eq("hold_ready_inflight", req_ready, 0);
`endif
        wait_cycles(15);
        expect_eq("wr_en_width", en_width, 3);
        expect_eq("wr_mem", mem[8'h45], 16'hBEEF);
        expect_eq("wr_issue_count", issued.size(), base + 1);
        expect_eq("wr_haddr", issued[base], 24'h012345);
        expect_eq("wr_no_rsp", rsp_count, 0);

        send(1'b0, 24'h012345, 16'h0000);
        wait_rsp("rd", 16'hBEEF, 1'b1);
        wait_cycles(3);
        expect_eq("rd_rsp_count", rsp_count, 1);

        m_lat = 12;
        send(1'b1, 24'h000100, 16'h1234);
        wait_cycles(30);
        expect_eq("refresh_en_width", en_width, 13);
        expect_eq("refresh_err", err, 0);
        expect_eq("refresh_mem", mem[8'h00], 16'h1234);
        m_lat = 2;

        m_stuck = 1'b1;
        send(1'b0, 24'h000200, 16'h0000);
        wait_rsp("to_rsp", 16'h0000, 1'b0);
        expect_eq("to_err", err, 1);
        expect_eq("to_en_width", en_width, ATO);
        expect_eq("to_idle_ready", req_ready, 1);
        m_stuck = 1'b0;

        send(1'b0, 24'h012345, 16'h0000);
        wait_rsp("rd2", 16'hBEEF, 1'b1);
        expect_eq("err_sticky", err, 1);

`ifdef SDRAM_HOST_REQ_FIFO_EN
        base = issued.size();
        for (int k = 0; k < 6; k++) begin
            send(1'b1, 24'h000300 + 24'(k), 16'h5000 + 16'(k));
            if (k == 4) expect_eq("bp_ready_full", req_ready, 0);
        end
        wait_cycles(80);
        expect_eq("bp_issue_count", issued.size(), base + 6);
        for (int k = 0; k < 6; k++) expect_eq("bp_order", issued[base + k], 24'h000300 + 24'(k));
        expect_eq("bp_mem_last", mem[8'h05], 16'h5005);
`endif

        m_len = 20;
        send(1'b0, 24'h012345, 16'h0000);
`ifdef SDRAM_HOST_REQ_FIFO_EN
        send(1'b1, 24'h000400, 16'hAAAA);
`endif
        n = 0;
        while (!(busy && !rd_enable) && n < 100) begin
            @(negedge clk);
            n++;
        end
        expect_eq("mid_active_seen", busy && !rd_enable, 1);
        rsp_snap = rsp_count;
        base = issued.size();
        rst_n = 1'b0;
        #1;
        expect_eq("mid_rd_en", rd_enable, 0);
        expect_eq("mid_wr_en", wr_enable, 0);
        expect_eq("mid_ready", req_ready, 0);
        expect_eq("mid_err", err, 0);
        @(negedge clk);
        m_len = 3;
        rst_n = 1'b1;
        wait_init("mid_init_restart");
        wait_cycles(20);
        expect_eq("mid_no_rsp", rsp_count, rsp_snap);
        expect_eq("mid_flushed", issued.size(), base);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog got=running exp=done");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
